// File: rtl/x_lut4_pkg.sv
// Shared types and widths for the reconfigurable LUT4 controller.
// Used by x_lut4_cfg_ctrl and x_lut4_shift16.
package x_lut4_pkg;
    localparam int LUT_W = 16;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;
endpackage

// File: rtl/x_lut4_shift16.sv
// Shadow shift register for the LUT4 controller.
// Serial input, parallel output, shifts MSB first.
module x_lut4_shift16
    import x_lut4_pkg::*;
(
    input  logic             clk,
    input  logic             srst,
    input  logic             shift_en,
    input  logic             sin,
    output logic [LUT_W-1:0] pout
);
    logic [LUT_W-1:0] shadow_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            shadow_reg <= '0;
        end else if (shift_en) begin
            shadow_reg <= {shadow_reg[LUT_W-2:0], sin};
        end
    end

    assign pout = shadow_reg;
endmodule

// File: rtl/x_lut4_cfg_ctrl.sv
// LUT4 with serial reconfiguration: a handshaked word is shifted into a shadow
// register over 16 cycles and then committed to the active table. Optional macro
// X_LUT4_CFG_READBACK_EN adds CFG_RDATA, a registered copy of the active table.
module x_lut4_cfg_ctrl
    import x_lut4_pkg::*;
#(
    parameter logic [15:0] INIT = 16'h0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CFG_VALID,
    input  logic [15:0] CFG_DATA,
    output logic        CFG_READY,
    output logic        CFG_BUSY,
    output logic        CFG_DONE,
    input  logic        ADR0,
    input  logic        ADR1,
    input  logic        ADR2,
    input  logic        ADR3,
`ifdef X_LUT4_CFG_READBACK_EN
    output logic [15:0] CFG_RDATA,
`endif
    output logic        O
);
    state_t           state_reg;
    logic [LUT_W-1:0] active_reg;
    logic [LUT_W-1:0] word_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             ready_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [LUT_W-1:0] shadow;
    logic [3:0]       adr;
    logic [LUT_W-1:0] hit;

    // 15-cnt for a 4-bit counter is its bitwise inverse: MSB goes out first.
    x_lut4_shift16 u_shift (
        .clk      (CLK),
        .srst     (RST),
        .shift_en (state_reg == SHIFT),
        .sin      (word_reg[~cnt_reg]),
        .pout     (shadow)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= IDLE;
            active_reg <= INIT;
            word_reg   <= '0;
            cnt_reg    <= '0;
            ready_reg  <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (CFG_VALID) begin
                        word_reg  <= CFG_DATA;
                        cnt_reg   <= '0;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(LUT_W - 1)) begin
                        done_reg  <= 1'b1;
                        state_reg <= COMMIT;
                    end
                end
                COMMIT: begin
                    active_reg <= shadow;
                    done_reg   <= 1'b0;
                    busy_reg   <= 1'b0;
                    ready_reg  <= 1'b1;
                    state_reg  <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    // One-hot decode of the address; only the selected table bit can reach O.
    assign adr = {ADR3, ADR2, ADR1, ADR0};
    for (genvar gi = 0; gi < LUT_W; gi++) begin : g_sel
        assign hit[gi] = active_reg[gi] && (adr == 4'(gi));
    end
    assign O = |hit;

    assign CFG_READY = ready_reg;
    assign CFG_BUSY  = busy_reg;
    assign CFG_DONE  = done_reg;
`ifdef X_LUT4_CFG_READBACK_EN
    assign CFG_RDATA = active_reg;
`endif
endmodule
